affine_op_ctrl_gen: RTL

- Generates the per-operation enable pulse (wen/ren) and the 16-bit ctrl_vars loop-index vector that unified-buffer ports use for address computation.
- Walks a 4-deep loop nest in lexicographic order. Index 3 is innermost, index 0 is outermost.
- Fires each iteration at the cycle given by an affine schedule.
- One instance drives each op write or read port of a buffer. It is the initiator side of the wen/ren + ctrl_vars interface.

---
 rtl/affine_ctrl_pkg.sv | 28 ++
 rtl/affine_ctrl_odometer.sv | 52 +++++
 rtl/affine_op_ctrl_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/affine_ctrl_pkg.sv
// Shared types and constants for the affine op controller: loop-nest geometry,
// index/coefficient vectors and the run-state encoding.
package affine_ctrl_pkg;

    localparam int NUM_DIMS = 4;
    localparam int W        = 16;
    localparam int CW       = 32;
    localparam int KW       = $clog2(NUM_DIMS);

    typedef logic [NUM_DIMS-1:0][W-1:0]  ctrl_vec_t;
    typedef logic [NUM_DIMS-1:0][CW-1:0] coeff_vec_t;
    typedef logic [KW-1:0]               dim_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Schedule cycles spanned by one full sweep of a dim: coeff * (extent - 1).
    function automatic logic [CW-1:0] span_cycles(input logic [CW-1:0] coeff,
                                                  input logic [W-1:0]  extent);
        logic [CW-1:0] ext_m1;
        ext_m1 = CW'(extent) - CW'(1);
        return coeff * ext_m1;
    endfunction

endpackage

// File: rtl/affine_ctrl_odometer.sv
// Loop-nest odometer: holds the pending iteration indices and advances them in
// lexicographic order (dim NUM_DIMS-1 innermost) with a wrap/carry chain.
module affine_ctrl_odometer
    import affine_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_i,
    input  logic      adv_i,
    input  ctrl_vec_t extent_i,
    output ctrl_vec_t idx_o,
    output dim_t      carry_dim_o,
    output logic      last_o
);

    ctrl_vec_t               idx_q, idx_d;
    logic [NUM_DIMS-1:0]     wrap;
    dim_t                    k;

    always_comb begin
        logic carry;
        carry = 1'b1;
        idx_d = idx_q;
        wrap  = '0;
        k     = '0;
        for (int i = NUM_DIMS - 1; i >= 0; i--) begin
            wrap[i] = (idx_q[i] == (extent_i[i] - W'(1)));
            if (carry) begin
                idx_d[i] = wrap[i] ? '0 : idx_q[i] + W'(1);
            end
            carry = carry & wrap[i];
        end
        // The dim that advances is the innermost one not sitting at its last value.
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (!wrap[i]) begin
                k = dim_t'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            idx_q <= '0;
        end else if (adv_i) begin
            idx_q <= idx_d;
        end
    end

    assign idx_o       = idx_q;
    assign carry_dim_o = k;
    assign last_o      = &wrap;

endmodule

// File: rtl/affine_op_ctrl_gen.sv
// Affine-schedule op controller: walks the loop nest and pulses en with the
// iteration indices once the cycle counter reaches each iteration's fire time.
module affine_op_ctrl_gen
    import affine_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          flush,
    input  logic          start,
    input  logic          stall,
    input  ctrl_vec_t     cfg_extent,
    input  coeff_vec_t    cfg_coeff,
    input  logic [CW-1:0] cfg_offset,
    output logic          en,
    output ctrl_vec_t     ctrl_vars,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pend_q, pend_d;
    ctrl_vec_t     ext_q, ext_d;
    coeff_vec_t    step_q, step_d;
    ctrl_vec_t     vars_q, vars_d;
    logic          en_q, en_d;
    logic          last_q, last_d;

    coeff_vec_t    step_new;
    logic          zero_ext;
    logic          fire;
    ctrl_vec_t     ext_src;
    coeff_vec_t    step_cur;
    logic [CW-1:0] pend_cur;
    ctrl_vec_t     odo_idx;
    dim_t          odo_k;
    logic          odo_last;

    // Fire-time increment when dim k advances and every inner dim rewinds to 0.
    always_comb begin
        logic [CW-1:0] tail;
        tail     = '0;
        step_new = '0;
        for (int k = NUM_DIMS - 1; k >= 0; k--) begin
            step_new[k] = cfg_coeff[k] - tail;
            tail        = tail + span_cycles(cfg_coeff[k], cfg_extent[k]);
        end
    end

    always_comb begin
        zero_ext = 1'b0;
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (cfg_extent[i] == '0) begin
                zero_ext = 1'b1;
            end
        end
    end

    // The first iteration may fire on the start edge, before the config is captured.
    assign ext_src  = (state_q == IDLE) ? cfg_extent : ext_q;
    assign step_cur = (state_q == IDLE) ? step_new   : step_q;
    assign pend_cur = (state_q == IDLE) ? cfg_offset : pend_q;

    affine_ctrl_odometer u_odometer (
        .clk         (clk),
        .rst_i       (flush),
        .adv_i       (fire),
        .extent_i    (ext_src),
        .idx_o       (odo_idx),
        .carry_dim_o (odo_k),
        .last_o      (odo_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ext_d   = ext_q;
        step_d  = step_q;
        vars_d  = vars_q;
        last_d  = last_q;
        en_d    = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_ext) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        ext_d   = cfg_extent;
                        step_d  = step_new;
                        pend_d  = cfg_offset;
                        vars_d  = '0;
                        last_d  = 1'b0;
                        fire    = !stall && (cfg_offset == '0);
                    end
                end
            end
            RUN: begin
                if (last_q) begin
                    state_d = DONE;
                end else if (!stall) begin
                    cnt_d = cnt_q + CW'(1);
                    fire  = ((cnt_q + CW'(1)) >= pend_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fire) begin
            en_d   = 1'b1;
            vars_d = odo_idx;
            pend_d = pend_cur + step_cur[odo_k];
            last_d = odo_last;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            vars_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            vars_q  <= vars_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        ext_q  <= ext_d;
        step_q <= step_d;
        pend_q <= pend_d;
    end

    assign en        = en_q;
    assign ctrl_vars = vars_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
